// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two core requesters (instruction fetch and load)
// and the ROM arbiter, plus the ROM-side address/data pair.
interface rom_arbiter_if;
  // instruction-fetch port
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  // load port
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        ls_err_o;
  // ROM side
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  // arbiter view
  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output rom_addr_o
  );

  // requester / ROM view
  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  rom_addr_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares one combinational-read ROM between the fetch (IF) and load (LS)
// ports. LS has fixed priority; a saturating wait counter forces an IF grant
// after MAX_WAIT consecutive denied IF cycles. Responses are registered and
// appear one cycle after the grant.
module rom_arbiter #(
  parameter int unsigned ROM_BYTES = 16384,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus
);

  // Out-of-range or misaligned accesses are answered with an error response.
  function automatic logic addr_error(input logic [31:0] addr);
    return (addr >= 32'(ROM_BYTES)) || (addr[1:0] != 2'b00);
  endfunction

  logic [3:0]  wait_cnt_r;
  logic        starve_s;
  logic        if_gnt_s;
  logic        ls_gnt_s;
  logic [31:0] sel_addr_s;
  logic        sel_err_s;

  logic        if_rvalid_r;
  logic [31:0] if_rdata_r;
  logic        if_err_r;
  logic        ls_rvalid_r;
  logic [31:0] ls_rdata_r;
  logic        ls_err_r;

  // Grant decision: LS wins unless IF has been starved long enough.
  always_comb begin
    starve_s = (wait_cnt_r >= 4'(MAX_WAIT));
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (!rst) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else begin
      if_gnt_s = bus.if_req_i & (~bus.ls_req_i | starve_s);
      ls_gnt_s = bus.ls_req_i & ~if_gnt_s;
    end
  end

  // ROM address follows the granted port; idle cycles present the IF address.
  always_comb begin
    sel_addr_s = bus.if_addr_i;
    if (ls_gnt_s) begin
      sel_addr_s = bus.ls_addr_i;
    end else begin
      sel_addr_s = bus.if_addr_i;
    end
    sel_err_s = addr_error(sel_addr_s);
  end

  // Response registers: capture ROM data (or zero on error) for the granted port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      if_err_r    <= 1'b0;
      ls_rvalid_r <= 1'b0;
      ls_rdata_r  <= 32'h0000_0000;
      ls_err_r    <= 1'b0;
    end else begin
      if_rvalid_r <= if_gnt_s;
      ls_rvalid_r <= ls_gnt_s;
      if (if_gnt_s) begin
        if_err_r   <= sel_err_s;
        if_rdata_r <= sel_err_s ? 32'h0000_0000 : bus.rom_data_i;
      end
      if (ls_gnt_s) begin
        ls_err_r   <= sel_err_s;
        ls_rdata_r <= sel_err_s ? 32'h0000_0000 : bus.rom_data_i;
      end
    end
  end

  // Starvation counter: counts consecutive denied IF cycles, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_r <= 4'd0;
    end else if (!bus.if_req_i || if_gnt_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != 4'hF) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end
  end

  assign bus.if_gnt_o    = if_gnt_s;
  assign bus.ls_gnt_o    = ls_gnt_s;
  assign bus.rom_addr_o  = sel_addr_s;
  assign bus.if_rvalid_o = if_rvalid_r;
  assign bus.if_rdata_o  = if_rdata_r;
  assign bus.if_err_o    = if_err_r;
  assign bus.ls_rvalid_o = ls_rvalid_r;
  assign bus.ls_rdata_o  = ls_rdata_r;
  assign bus.ls_err_o    = ls_err_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them when rvalid appears.
module tb_rom_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  rsp_t exp_if[$];
  rsp_t exp_ls[$];

  rom_arbiter_if bus ();

  rom_arbiter #(.ROM_BYTES(16384), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM contents: recognisable, nonzero word per index
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0000, a[17:2]};
  endfunction

  assign bus.rom_data_i = rom_word(bus.rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic rsp_t make_rsp(input logic [31:0] a);
    rsp_t r;
    r.err  = (a >= 32'h0000_4000) || (a[1:0] != 2'b00);
    r.data = r.err ? 32'h0000_0000 : rom_word(a);
    r.cyc  = cyc + 1;
    return r;
  endfunction

  // one clock cycle of stimulus with expected grants
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la,
                      input logic eig, input logic elg, input string tag);
    bus.if_req_i  = ir;
    bus.if_addr_i = ia;
    bus.ls_req_i  = lr;
    bus.ls_addr_i = la;
    @(negedge clk);
    chk({tag, " if_gnt"}, {31'd0, bus.if_gnt_o}, {31'd0, eig});
    chk({tag, " ls_gnt"}, {31'd0, bus.ls_gnt_o}, {31'd0, elg});
    chk({tag, " rom_addr"}, bus.rom_addr_o, elg ? la : ia);
    if (eig) exp_if.push_back(make_rsp(ia));
    if (elg) exp_ls.push_back(make_rsp(la));
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every response against the scoreboard
  always @(negedge clk) begin
    rsp_t e;
    if (bus.if_rvalid_o === 1'b1) begin
      if (exp_if.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL if_rsp unexpected rvalid at cycle %0d (required none)", cyc);
      end else begin
        e = exp_if.pop_front();
        chk("if_rsp cycle", 32'(cyc), 32'(e.cyc));
        chk("if_rsp rdata", bus.if_rdata_o, e.data);
        chk("if_rsp err", {31'd0, bus.if_err_o}, {31'd0, e.err});
      end
    end
    if (bus.ls_rvalid_o === 1'b1) begin
      if (exp_ls.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL ls_rsp unexpected rvalid at cycle %0d (required none)", cyc);
      end else begin
        e = exp_ls.pop_front();
        chk("ls_rsp cycle", 32'(cyc), 32'(e.cyc));
        chk("ls_rsp rdata", bus.ls_rdata_o, e.data);
        chk("ls_rsp err", {31'd0, bus.ls_err_o}, {31'd0, e.err});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = 32'h0;
    bus.ls_req_i  = 1'b0;
    bus.ls_addr_i = 32'h0;
    @(posedge clk);
    #1;

    // 1. reset with requests asserted: no grants, outputs cleared
    step(1'b1, 32'h0, 1'b1, 32'h8, 1'b0, 1'b0, "rst1");
    step(1'b1, 32'h0, 1'b1, 32'h8, 1'b0, 1'b0, "rst2");
    chk("rst if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
    chk("rst if_rdata", bus.if_rdata_o, 32'd0);
    chk("rst if_err", {31'd0, bus.if_err_o}, 32'd0);
    chk("rst ls_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd0);
    chk("rst ls_rdata", bus.ls_rdata_o, 32'd0);
    chk("rst wait_cnt", {28'd0, dut.wait_cnt_r}, 32'd0);
    rst = 1'b1;
    // IF only, back to back
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, "if0");
    step(1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, "if1");
    step(1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, "if2");
    step(1'b0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, "idle_a");

    // 2. contention: LS first, IF next cycle
    step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, "cont0");
    step(1'b1, 32'h10, 1'b0, 32'h20, 1'b1, 1'b0, "cont1");
    step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, "idle_b");

    // 3. starvation with MAX_WAIT=4
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h8, 1'b1, 32'(32'h20 + 4 * i), 1'b0, 1'b1, "starve_deny");
    chk("wait_cnt saturated at threshold", {28'd0, dut.wait_cnt_r}, 32'd4);
    step(1'b1, 32'h8, 1'b1, 32'h30, 1'b1, 1'b0, "starve_force");
    chk("wait_cnt after forced grant", {28'd0, dut.wait_cnt_r}, 32'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hC, 1'b1, 32'(32'h30 + 4 * i), 1'b0, 1'b1, "starve_deny2");
    step(1'b1, 32'hC, 1'b1, 32'h40, 1'b1, 1'b0, "starve_force2");
    step(1'b0, 32'hC, 1'b1, 32'h40, 1'b0, 1'b1, "starve_ls");
    step(1'b0, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, "idle_c");

    // 4. error responses and last valid word
    step(1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 1'b1, "err_range");
    step(1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 1'b1, "err_align");
    step(1'b1, 32'h3FFC, 1'b0, 32'h0, 1'b1, 1'b0, "last_word");
    step(1'b1, 32'h4001, 1'b0, 32'h0, 1'b1, 1'b0, "if_err");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "idle_d");

    // 5. reset right after a grant
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, "pre_rst");
    rst = 1'b0;
    step(1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0, "mid_rst1");
    chk("mid_rst if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
    chk("mid_rst if_rdata", bus.if_rdata_o, 32'd0);
    step(1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0, "mid_rst2");
    rst = 1'b1;

    // 6. idle
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
      chk("idle wait_cnt", {28'd0, dut.wait_cnt_r}, 32'd0);
    end

    // drain: every expected response must have been delivered
    repeat (2) @(posedge clk);
    #1;
    chk("if scoreboard drained", 32'(exp_if.size()), 32'd0);
    chk("ls scoreboard drained", 32'(exp_ls.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
